// File: rtl/controle_bomba_pkg.sv
// Shared types and helpers for the bomb game controller (controle_bomba).
package bomba_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      DEFUSED  = 2'd2,
      EXPLODED = 2'd3
   } estado_t;

   localparam int CODE_DIGITS = 4;

   // Digit 0 is the most significant nibble of the code.
   function automatic logic [3:0] digito_codigo(input logic [15:0] code,
                                                input logic [1:0]  idx);
      logic [15:0] sh;
      sh = code >> (4 * (CODE_DIGITS - 1 - int'(idx)));
      return sh[3:0];
   endfunction

endpackage

// File: rtl/controle_bomba_detector_borda.sv
// Registered rising-edge detector for one key input.
// The input is registered once; the edge flag is registered as well, so an
// input first seen high at edge k is reported by edge_o after edge k and acted
// on by the consumer at edge k+1.
module detector_borda (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   output logic edge_o
);

   logic in_q;
   logic edge_q;

   // During reset the history register tracks the input, so a key held
   // through reset release only counts once it has gone low and risen again.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         in_q   <= in_i;
         edge_q <= 1'b0;
      end else begin
         in_q   <= in_i;
         edge_q <= in_i & ~in_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/controle_bomba.sv
// Game-sequencing controller for the bomb clock.
// Arms the countdown timer on START, checks a 4-digit code entered digit by
// digit with CONFIRM, and reports defused / exploded.
// Optional feature macro: STRIKES_EN (wrong entries counted as strikes up to
// N_STRIKES; without it any wrong digit explodes the bomb at once).
module controle_bomba
   import bomba_pkg::*;
#(
   parameter logic [15:0] CODE      = 16'h1234,
   parameter int          N_STRIKES = 3
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       START,
   input  logic       CONFIRM,
   input  logic [0:3] DIGITO,
   input  logic       TEMPO_ACABOU,
   output logic       TIMER_RESET,
   output logic       TIMER_PAUSE,
   output logic       ARMADO,
   output logic       DESARMADO,
   output logic       EXPLODIU,
   output logic [0:2] PROGRESSO,
   output logic [0:1] STRIKES
);

   if (N_STRIKES < 1 || N_STRIKES > 3) begin : g_bad_strikes
      $error("controle_bomba: N_STRIKES must be in 1..3");
   end

   logic start_edge;
   logic confirm_edge;

   detector_borda u_borda_start (
      .clk_i  (CLOCK),
      .rst_ni (RESET_N),
      .in_i   (START),
      .edge_o (start_edge)
   );

   detector_borda u_borda_confirm (
      .clk_i  (CLOCK),
      .rst_ni (RESET_N),
      .in_i   (CONFIRM),
      .edge_o (confirm_edge)
   );

   estado_t    state_q, state_d;
   logic [2:0] prog_q, prog_d;
   logic [1:0] strikes_q, strikes_d;
   logic       timer_reset_q, timer_reset_d;
   logic       timer_pause_q, timer_pause_d;
   logic       armado_q, armado_d;
   logic       desarmado_q, desarmado_d;
   logic       explodiu_q, explodiu_d;

   logic [3:0] digito;
   logic       digito_ok;

   assign digito    = DIGITO;
   // Switch values above 9 are never a valid BCD digit, whatever CODE holds.
   assign digito_ok = (digito <= 4'd9) &&
                      (digito == digito_codigo(CODE, prog_q[1:0]));

`ifdef STRIKES_EN
   localparam logic [1:0] StrikeLimit = 2'(N_STRIKES);
   logic [1:0] strikes_inc;
   assign strikes_inc = strikes_q + 2'd1;
`endif

   // Next state and next registered outputs; timeout wins over a digit entry.
   always_comb begin
      state_d       = state_q;
      prog_d        = prog_q;
      strikes_d     = strikes_q;
      timer_reset_d = 1'b0;
      case (state_q)
         ARMED: begin
            if (TEMPO_ACABOU) begin
               state_d = EXPLODED;
            end else if (confirm_edge) begin
               if (digito_ok) begin
                  prog_d = prog_q + 3'd1;
                  if (prog_q == 3'(CODE_DIGITS - 1)) begin
                     state_d = DEFUSED;
                  end
               end else begin
                  prog_d = 3'd0;
`ifdef STRIKES_EN
                  strikes_d = strikes_inc;
                  if (strikes_inc == StrikeLimit) begin
                     state_d = EXPLODED;
                  end
`else
                  state_d = EXPLODED;
`endif
               end
            end
         end
         default: begin
            // IDLE, DEFUSED and EXPLODED all arm on START and ignore CONFIRM.
            if (start_edge) begin
               state_d       = ARMED;
               prog_d        = 3'd0;
               strikes_d     = 2'd0;
               timer_reset_d = 1'b1;
            end
         end
      endcase
      timer_pause_d = (state_d != ARMED);
      armado_d      = (state_d == ARMED);
      desarmado_d   = (state_d == DEFUSED);
      explodiu_d    = (state_d == EXPLODED);
   end

   // State and output registers; reset holds the timer paused without a pulse.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_q       <= IDLE;
         prog_q        <= 3'd0;
         strikes_q     <= 2'd0;
         timer_reset_q <= 1'b0;
         timer_pause_q <= 1'b1;
         armado_q      <= 1'b0;
         desarmado_q   <= 1'b0;
         explodiu_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         prog_q        <= prog_d;
         strikes_q     <= strikes_d;
         timer_reset_q <= timer_reset_d;
         timer_pause_q <= timer_pause_d;
         armado_q      <= armado_d;
         desarmado_q   <= desarmado_d;
         explodiu_q    <= explodiu_d;
      end
   end

   assign TIMER_RESET = timer_reset_q;
   assign TIMER_PAUSE = timer_pause_q;
   assign ARMADO      = armado_q;
   assign DESARMADO   = desarmado_q;
   assign EXPLODIU    = explodiu_q;
   assign PROGRESSO   = prog_q;
   assign STRIKES     = strikes_q;

endmodule

// File: tb/tb_controle_bomba.sv
// Testbench for controle_bomba (CODE=16'h1234, N_STRIKES=3).
// Expectations follow the STRIKES_EN macro so the same bench covers both builds.
module tb_controle_bomba;

   logic       CLOCK = 1'b0;
   logic       RESET_N;
   logic       START;
   logic       CONFIRM;
   logic [0:3] DIGITO;
   logic       TEMPO_ACABOU;
   logic       TIMER_RESET;
   logic       TIMER_PAUSE;
   logic       ARMADO;
   logic       DESARMADO;
   logic       EXPLODIU;
   logic [0:2] PROGRESSO;
   logic [0:1] STRIKES;

`ifdef STRIKES_EN
   localparam bit STR_EN = 1'b1;
`else
   localparam bit STR_EN = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Packed outputs: {reset, pause, armado, desarmado, explodiu, prog[3], strikes[2]}
   logic [9:0] exp_q[$];

   typedef struct {
      logic       st;
      logic       cf;
      logic [3:0] dg;
      logic       ta;
      logic [9:0] exp_o;
   } vec_t;

   vec_t tab[12];

   controle_bomba #(.CODE(16'h1234), .N_STRIKES(3)) dut (
      .CLOCK        (CLOCK),
      .RESET_N      (RESET_N),
      .START        (START),
      .CONFIRM      (CONFIRM),
      .DIGITO       (DIGITO),
      .TEMPO_ACABOU (TEMPO_ACABOU),
      .TIMER_RESET  (TIMER_RESET),
      .TIMER_PAUSE  (TIMER_PAUSE),
      .ARMADO       (ARMADO),
      .DESARMADO    (DESARMADO),
      .EXPLODIU     (EXPLODIU),
      .PROGRESSO    (PROGRESSO),
      .STRIKES      (STRIKES)
   );

   // Clock
   always #5 CLOCK = ~CLOCK;

   function automatic logic [9:0] ex(input bit r, input bit p, input bit a,
                                     input bit d, input bit e, input int pr,
                                     input int s);
      return {r, p, a, d, e, 3'(pr), 2'(s)};
   endfunction

   // One clock edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic drive(input bit st, input bit cf, input logic [3:0] dg, input bit ta);
      START        = st;
      CONFIRM      = cf;
      DIGITO       = dg;
      TEMPO_ACABOU = ta;
   endtask

   task automatic check(input string name, input logic [9:0] e);
      logic [9:0] act;
      act = {TIMER_RESET, TIMER_PAUSE, ARMADO, DESARMADO, EXPLODIU, PROGRESSO, STRIKES};
      n_tests++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s: got rst=%b pause=%b arm=%b def=%b exp=%b prog=%0d str=%0d, want rst=%b pause=%b arm=%b def=%b exp=%b prog=%0d str=%0d",
                  name, act[9], act[8], act[7], act[6], act[5], act[4:2], act[1:0],
                  e[9], e[8], e[7], e[6], e[5], e[4:2], e[1:0]);
      end
   endtask

   task automatic do_reset();
      drive(0, 0, 4'd0, 0);
      RESET_N = 1'b0;
      step();
      step();
      RESET_N = 1'b1;
   endtask

   // START pulse from a non-armed state; checks the one-cycle timer reset.
   task automatic arm(input string name);
      drive(1, 0, 4'd0, 0);
      step();
      drive(0, 0, 4'd0, 0);
      step();
      check({name, "_pulse"}, ex(1, 0, 1, 0, 0, 0, 0));
      step();
      check({name, "_pulse_end"}, ex(0, 0, 1, 0, 0, 0, 0));
   endtask

   // CONFIRM rise with the digit held across the update edge.
   task automatic confirm(input logic [3:0] dg);
      drive(0, 1, dg, 0);
      step();
      drive(0, 0, dg, 0);
      step();
   endtask

   initial begin
      drive(0, 0, 4'd0, 0);
      RESET_N = 1'b0;

      // ---------------- reset state + correct code table ----------------
      do_reset();
      check("reset_state", ex(0, 1, 0, 0, 0, 0, 0));

      tab[0]  = '{1, 0, 4'd0, 0, ex(0, 1, 0, 0, 0, 0, 0)};
      tab[1]  = '{0, 0, 4'd0, 0, ex(1, 0, 1, 0, 0, 0, 0)};
      tab[2]  = '{0, 1, 4'd1, 0, ex(0, 0, 1, 0, 0, 0, 0)};
      tab[3]  = '{0, 0, 4'd1, 0, ex(0, 0, 1, 0, 0, 1, 0)};
      tab[4]  = '{0, 1, 4'd2, 0, ex(0, 0, 1, 0, 0, 1, 0)};
      tab[5]  = '{0, 0, 4'd2, 0, ex(0, 0, 1, 0, 0, 2, 0)};
      tab[6]  = '{0, 1, 4'd3, 0, ex(0, 0, 1, 0, 0, 2, 0)};
      tab[7]  = '{0, 0, 4'd3, 0, ex(0, 0, 1, 0, 0, 3, 0)};
      tab[8]  = '{0, 1, 4'd4, 0, ex(0, 0, 1, 0, 0, 3, 0)};
      tab[9]  = '{0, 0, 4'd4, 0, ex(0, 1, 0, 1, 0, 4, 0)};
      tab[10] = '{0, 1, 4'd5, 0, ex(0, 1, 0, 1, 0, 4, 0)};
      tab[11] = '{0, 0, 4'd5, 0, ex(0, 1, 0, 1, 0, 4, 0)};

      foreach (tab[i]) exp_q.push_back(tab[i].exp_o);
      for (int i = 0; i < 12; i++) begin
         logic [9:0] e;
         drive(tab[i].st, tab[i].cf, tab[i].dg, tab[i].ta);
         step();
         e = exp_q.pop_front();
         check($sformatf("code_row%0d", i), e);
      end

      // ---------------- strikes / wrong digit ----------------
      do_reset();
      arm("strk_arm");
      confirm(4'd1);
      check("strk_ok1", ex(0, 0, 1, 0, 0, 1, 0));
      confirm(4'd9);
      if (STR_EN) begin
         check("strk_1", ex(0, 0, 1, 0, 0, 0, 1));
         confirm(4'd9);
         check("strk_2", ex(0, 0, 1, 0, 0, 0, 2));
         confirm(4'd15);
         check("strk_3_boom", ex(0, 1, 0, 0, 1, 0, 3));
      end else begin
         check("wrong_boom", ex(0, 1, 0, 0, 1, 0, 0));
         confirm(4'd1);
         check("wrong_boom_hold", ex(0, 1, 0, 0, 1, 0, 0));
      end

      // ---------------- timeout ----------------
      do_reset();
      arm("tmo_arm");
      confirm(4'd1);
      drive(0, 0, 4'd0, 1);
      step();
      check("tmo_boom", ex(0, 1, 0, 0, 1, 1, 0));
      drive(0, 0, 4'd0, 0);
      confirm(4'd2);
      check("tmo_confirm_ignored", ex(0, 1, 0, 0, 1, 1, 0));

      // ---------------- re-arm from EXPLODED ----------------
      arm("rearm");
      confirm(4'd7);
      if (STR_EN) check("rearm_wrong", ex(0, 0, 1, 0, 0, 0, 1));
      else        check("rearm_wrong", ex(0, 1, 0, 0, 1, 0, 0));

      // ---------------- last digit together with timeout ----------------
      do_reset();
      arm("sim_arm");
      confirm(4'd1);
      confirm(4'd2);
      confirm(4'd3);
      check("sim_prog3", ex(0, 0, 1, 0, 0, 3, 0));
      drive(0, 1, 4'd4, 0);
      step();
      drive(0, 0, 4'd4, 1);
      step();
      check("sim_timeout_wins", ex(0, 1, 0, 0, 1, 3, 0));
      drive(0, 0, 4'd0, 0);

      // ---------------- reset mid-game, START held through release ----------------
      do_reset();
      arm("mid_arm");
      if (STR_EN) confirm(4'd8);
      confirm(4'd1);
      confirm(4'd2);
      check("mid_before", ex(0, 0, 1, 0, 0, 2, STR_EN ? 1 : 0));
      START   = 1'b1;
      RESET_N = 1'b0;
      step();
      check("mid_reset", ex(0, 1, 0, 0, 0, 0, 0));
      RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("mid_held%0d", i), ex(0, 1, 0, 0, 0, 0, 0));
      end
      START = 1'b0;
      step();
      step();
      check("mid_release_idle", ex(0, 1, 0, 0, 0, 0, 0));
      arm("mid_rearm");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
